alu_arith_mc: RTL and testbench
===============================

ALU_ARITH_MC -- requirements
Module: alu_arith_mc

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand/result width (legal range 8..64).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 in_valid  in  1  request valid.
REQ-005 in_ready  out  1  request accepted when in_valid && in_ready.
REQ-006 op  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100-111 reserved.
REQ-007 sign  in  1  1 = signed (two's complement), 0 = unsigned.
REQ-008 a, b  in  WIDTH  operands.
REQ-009 out_valid  out  1  result valid.
REQ-010 out_ready  in  1  result consumed when out_valid && out_ready.
REQ-011 result  out  WIDTH  sum/difference/product low/quotient.
REQ-012 result_hi  out  WIDTH  product high/remainder; 0 for ADD/SUB.
REQ-013 z, v, n  out  1 each  zero, overflow, negative/less-than flags.

Function
REQ-014 FSM states SHALL be IDLE, RUN, FIX, DONE; in_ready = (state == IDLE).
REQ-015 IDLE + accept of ADD, SUB, reserved op, or DIV with b == 0 -> DONE; out_valid at accept cycle k+1.
REQ-016 IDLE + accept of MUL or DIV (b != 0) -> RUN for exactly WIDTH cycles -> FIX 1 cycle -> DONE; out_valid at k+WIDTH+2.
REQ-017 DONE && out_ready -> IDLE; result, result_hi, z, v, n SHALL hold stable while out_valid && !out_ready.
REQ-018 Operands and op SHALL be registered at accept; input changes after accept SHALL not affect the result.
REQ-019 ADD/SUB: result = (a +/- b) mod 2^WIDTH; z = (result == 0).
REQ-020 ADD/SUB signed: v = signed overflow; n = v XOR result[WIDTH-1].
REQ-021 ADD unsigned: v = carry-out, n = 0; SUB unsigned: v = n = borrow (a < b).
REQ-022 MUL: iterative shift-add on magnitudes, sign fixup in FIX when sign=1 and operand signs differ; {result_hi,result} = full 2*WIDTH product.
REQ-023 MUL flags: z = (full product == 0); n = result_hi[WIDTH-1] (signed) else 0; v = 1 iff result_hi is not the sign/zero extension of result.
REQ-024 DIV: restoring division on magnitudes; quotient negated if sign && a,b signs differ; remainder takes sign of a; quotient truncates toward zero.
REQ-025 DIV flags: z = (quotient == 0); n = quotient[WIDTH-1] if signed else 0; v = 0 unless REQ-026/027.
REQ-026 DIV b == 0: result = all ones, result_hi = a, v = 1, z = 0, n = 0.
REQ-027 Signed DIV of most-negative by -1: result = most-negative, result_hi = 0, v = 1, n = 1.
REQ-028 Reserved op: result = result_hi = 0, z = 1, v = n = 0.

Reset
REQ-029 reset low at any edge SHALL force state IDLE, out_valid 0, result/result_hi 0, z/v/n 0, iteration counter 0.
REQ-030 Reset during RUN/FIX/DONE SHALL abort the operation with no out_valid pulse; in_ready = 1 on first cycle after release.

Structure
REQ-031 Package alu_arith_pkg SHALL hold op encodings, FSM state type, and WIDTH default.
REQ-032 Combinational sub-module alu_addsub (parameter WIDTH: a, b, sub, sign -> sum, z, v, n) SHALL implement REQ-019..021 and be reused by the MUL/DIV datapath.
REQ-033 Iteration counter SHALL be $clog2(WIDTH)+1 bits.

Verification (WIDTH=32)
REQ-034 ADD sign=1 a=0x7FFFFFFF b=1 -> result 0x80000000, v=1, n=0, z=0, out_valid at k+1.
REQ-035 SUB sign=0 a=3 b=5 -> result 0xFFFFFFFE, v=1, n=1; SUB a=b=0x1234 -> result 0, z=1.
REQ-036 MUL sign=1 a=0xFFFFFFFD b=7 -> result 0xFFFFFFEB, result_hi 0xFFFFFFFF, v=0, n=1, out_valid at k+34.
REQ-037 DIV sign=1 a=0xFFFFFFF9 b=2 -> result 0xFFFFFFFD, result_hi 0xFFFFFFFF; DIV b=0 a=5 -> result 0xFFFFFFFF, result_hi 5, v=1, at k+1.
REQ-038 DIV sign=1 a=0x80000000 b=0xFFFFFFFF -> result 0x80000000, result_hi 0, v=1.
REQ-039 out_ready held low 5 cycles after out_valid -> outputs stable, in_ready 0; reset pulsed at RUN cycle 10 of a MUL -> no out_valid, in_ready 1 next cycle after release.

Source files
------------

// File: rtl/alu_arith_pkg.sv
// -----------------------------------------------------------------------------
// alu_arith_pkg
// Shared definitions for the multi-cycle arithmetic unit: operation encodings,
// the controller state type and the default datapath width.
// -----------------------------------------------------------------------------
package alu_arith_pkg;

    // Default operand/result width (legal range 8..64)
    localparam int WIDTH_DEFAULT = 32;

    // Operation encodings; 3'b100..3'b111 are reserved
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    // Controller states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_addsub.sv
// -----------------------------------------------------------------------------
// alu_addsub
// Combinational adder/subtractor with flag generation.
//   a, b  : operands
//   sub   : 1 = a - b, 0 = a + b
//   sign  : 1 = two's complement flags, 0 = unsigned flags
//   sum   : (a +/- b) mod 2^WIDTH
//   z     : sum == 0
//   v     : signed overflow (sign=1), carry-out on add / borrow on sub (sign=0)
//   n     : v ^ sum[msb] (sign=1), 0 on unsigned add, borrow on unsigned sub
// -----------------------------------------------------------------------------
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sign,
    output logic [WIDTH-1:0] sum,
    output logic             z,
    output logic             v,
    output logic             n
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;
    logic             carry;
    logic             ovf;

    // Subtraction is a + ~b + 1, so the carry-out is the inverse of the borrow.
    // Signed overflow: both addends share a sign that the sum does not.
    always_comb begin
        b_eff = sub ? ~b : b;
        full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        sum   = full[WIDTH-1:0];
        carry = full[WIDTH];
        ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        z     = (sum == {WIDTH{1'b0}});
        if (sign) begin
            v = ovf;
            n = ovf ^ sum[WIDTH-1];
        end else if (sub) begin
            v = ~carry;
            n = ~carry;
        end else begin
            v = carry;
            n = 1'b0;
        end
    end

endmodule

// File: rtl/alu_arith_mc.sv
// -----------------------------------------------------------------------------
// alu_arith_mc
// Multi-cycle integer ALU: single-cycle ADD/SUB, iterative shift-add MUL and
// restoring DIV on operand magnitudes with a one-cycle sign fixup.
//   clk, reset          : clock, synchronous active-low reset
//   in_valid/in_ready   : request handshake (in_ready high only when idle)
//   op, sign, a, b      : operation, signedness, operands (captured at accept)
//   out_valid/out_ready : result handshake; outputs hold until consumed
//   result, result_hi   : sum/diff/product-low/quotient, product-high/remainder
//   z, v, n             : zero, overflow, negative/less-than flags
// -----------------------------------------------------------------------------
module alu_arith_mc
    import alu_arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             z,
    output logic             v,
    output logic             n
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state;
    logic [2:0]         op_q;
    logic               sign_q;
    logic               neg_q;
    logic               rem_neg_q;
    logic               div_ovf_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [CNT_W-1:0]   cnt;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH-1:0]   as_a;
    logic [WIDTH-1:0]   as_b;
    logic               as_sub;
    logic               as_sign;
    logic [WIDTH-1:0]   as_sum;
    logic               as_z;
    logic               as_v;
    logic               as_n;

    logic [WIDTH-1:0]   div_shift;
    logic               div_ge;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   remd;
    logic [WIDTH-1:0]   fix_result;
    logic [WIDTH-1:0]   fix_result_hi;
    logic               fix_z;
    logic               fix_v;
    logic               fix_n;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // Operand magnitudes for MUL/DIV. The most-negative value maps onto
    // itself, which is the correct unsigned magnitude 2^(WIDTH-1).
    always_comb begin
        a_neg = sign & a[WIDTH-1];
        b_neg = sign & b[WIDTH-1];
        a_mag = a_neg ? ({WIDTH{1'b0}} - a) : a;
        b_mag = b_neg ? ({WIDTH{1'b0}} - b) : b;
    end

    // One adder serves every path: while idle it evaluates ADD/SUB straight
    // from the inputs; while running it is the MUL accumulate adder or the
    // DIV trial subtractor on the working registers. In DIV the partial
    // remainder is shifted left one bit and its top bit lives in hi_q[msb];
    // when that bit is set the value already exceeds any divisor.
    always_comb begin
        div_shift = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        as_a      = a;
        as_b      = b;
        as_sub    = (op == OP_SUB);
        as_sign   = sign;
        if (state == S_RUN) begin
            as_sign = 1'b0;
            as_b    = opnd_q;
            if (op_q == OP_DIV) begin
                as_a   = div_shift;
                as_sub = 1'b1;
            end else begin
                as_a   = hi_q;
                as_sub = 1'b0;
            end
        end
    end

    assign div_ge = hi_q[WIDTH-1] | ~as_v;

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a    (as_a),
        .b    (as_b),
        .sub  (as_sub),
        .sign (as_sign),
        .sum  (as_sum),
        .z    (as_z),
        .v    (as_v),
        .n    (as_n)
    );

    // Sign fixup and flag generation for the iterative operations. The
    // product is negated as a full double-width value; the quotient takes
    // the XOR of operand signs and the remainder follows the dividend.
    always_comb begin
        prod          = {hi_q, lo_q};
        if (neg_q) begin
            prod = {(2*WIDTH){1'b0}} - {hi_q, lo_q};
        end
        quot          = neg_q ? ({WIDTH{1'b0}} - lo_q) : lo_q;
        remd          = rem_neg_q ? ({WIDTH{1'b0}} - hi_q) : hi_q;
        fix_result    = quot;
        fix_result_hi = remd;
        fix_z         = (quot == {WIDTH{1'b0}});
        fix_n         = sign_q & quot[WIDTH-1];
        fix_v         = 1'b0;
        if (op_q == OP_MUL) begin
            fix_result    = prod[WIDTH-1:0];
            fix_result_hi = prod[2*WIDTH-1:WIDTH];
            fix_z         = (prod == {(2*WIDTH){1'b0}});
            fix_n         = sign_q & prod[2*WIDTH-1];
            if (sign_q) begin
                fix_v = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
            end else begin
                fix_v = (prod[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
            end
        end else if (div_ovf_q) begin
            fix_result    = MOST_NEG;
            fix_result_hi = {WIDTH{1'b0}};
            fix_z         = 1'b0;
            fix_n         = 1'b1;
            fix_v         = 1'b1;
        end
    end

    // Controller and datapath registers. Fast operations write the outputs
    // at accept and go straight to DONE; MUL/DIV spend exactly WIDTH cycles
    // in RUN, one in FIX, then present the result in DONE until consumed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            op_q      <= OP_ADD;
            sign_q    <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div_ovf_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            cnt       <= '0;
            result    <= '0;
            result_hi <= '0;
            z         <= 1'b0;
            v         <= 1'b0;
            n         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q      <= op;
                        sign_q    <= sign;
                        cnt       <= '0;
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= (op == OP_DIV) & a_neg;
                        div_ovf_q <= sign && (a == MOST_NEG) && (b == {WIDTH{1'b1}});
                        hi_q      <= '0;
                        lo_q      <= a_mag;
                        opnd_q    <= b_mag;
                        if (op == OP_ADD || op == OP_SUB) begin
                            result    <= as_sum;
                            result_hi <= '0;
                            z         <= as_z;
                            v         <= as_v;
                            n         <= as_n;
                            state     <= S_DONE;
                        end else if (op == OP_MUL || (op == OP_DIV && b != '0)) begin
                            state <= S_RUN;
                        end else if (op == OP_DIV) begin
                            result    <= {WIDTH{1'b1}};
                            result_hi <= a;
                            z         <= 1'b0;
                            v         <= 1'b1;
                            n         <= 1'b0;
                            state     <= S_DONE;
                        end else begin
                            result    <= '0;
                            result_hi <= '0;
                            z         <= 1'b1;
                            v         <= 1'b0;
                            n         <= 1'b0;
                            state     <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (op_q == OP_DIV) begin
                        hi_q <= div_ge ? as_sum : div_shift;
                        lo_q <= {lo_q[WIDTH-2:0], div_ge};
                    end else if (lo_q[0]) begin
                        hi_q <= {as_v, as_sum[WIDTH-1:1]};
                        lo_q <= {as_sum[0], lo_q[WIDTH-1:1]};
                    end else begin
                        hi_q <= {1'b0, hi_q[WIDTH-1:1]};
                        lo_q <= {hi_q[0], lo_q[WIDTH-1:1]};
                    end
                    cnt <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    result    <= fix_result;
                    result_hi <= fix_result_hi;
                    z         <= fix_z;
                    v         <= fix_v;
                    n         <= fix_n;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arith_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_arith_mc
// Directed self-checking bench for alu_arith_mc at WIDTH=32. Expected values
// are hand-computed constants; outputs are sampled 1 time unit after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_alu_arith_mc;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic        sign = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        z;
    logic        v;
    logic        n;

    int total = 0;
    int bad = 0;

    alu_arith_mc #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .sign      (sign),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .z         (z),
        .v         (v),
        .n         (n)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    // Safety net in case the sequence below ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one request, hold it for the accepting edge, then scramble the
    // inputs so any late sampling of them would corrupt the result.
    task automatic apply_stimulus(input logic [2:0] t_op, input logic t_sign,
                                  input logic [31:0] t_a, input logic [31:0] t_b);
        op       = t_op;
        sign     = t_sign;
        a        = t_a;
        b        = t_b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 3'b001;
        sign     = ~t_sign;
        a        = 32'hDEADBEEF;
        b        = 32'h5A5A5A5A;
    endtask

    // Counts rising edges after the accepting edge until out_valid is seen
    task automatic wait_result(input int max_cycles, output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < max_cycles) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_all(input string tag, input int lat, input int e_lat,
                             input logic [31:0] e_res, input logic [31:0] e_hi,
                             input logic e_z, input logic e_v, input logic e_n);
        check_output({tag, ".out_valid"}, out_valid, 1);
        check_output({tag, ".latency"}, lat, e_lat);
        check_output({tag, ".result"}, result, e_res);
        check_output({tag, ".result_hi"}, result_hi, e_hi);
        check_output({tag, ".z"}, z, e_z);
        check_output({tag, ".v"}, v, e_v);
        check_output({tag, ".n"}, n, e_n);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_output({tag, ".idle_after"}, in_ready, 1);
        check_output({tag, ".valid_after"}, out_valid, 0);
    endtask

    initial begin
        int lat;
        logic seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        check_output("rst.in_ready", in_ready, 1);
        check_output("rst.out_valid", out_valid, 0);
        check_output("rst.result", result, 0);
        check_output("rst.result_hi", result_hi, 0);
        check_output("rst.flags", {z, v, n}, 3'b000);

        // Signed ADD overflow
        apply_stimulus(3'b000, 1'b1, 32'h7FFFFFFF, 32'h00000001);
        wait_result(5, lat);
        check_all("add_s_ovf", lat, 0, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0);
        consume("add_s_ovf");

        // Unsigned ADD carry-out with zero result
        apply_stimulus(3'b000, 1'b0, 32'hFFFFFFFF, 32'h00000001);
        wait_result(5, lat);
        check_all("add_u_carry", lat, 0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        consume("add_u_carry");

        // Unsigned SUB with borrow
        apply_stimulus(3'b001, 1'b0, 32'd3, 32'd5);
        wait_result(5, lat);
        check_all("sub_u_borrow", lat, 0, 32'hFFFFFFFE, 32'h0, 1'b0, 1'b1, 1'b1);
        consume("sub_u_borrow");

        // SUB to zero
        apply_stimulus(3'b001, 1'b0, 32'h1234, 32'h1234);
        wait_result(5, lat);
        check_all("sub_zero", lat, 0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        consume("sub_zero");

        // Signed MUL -3 * 7, then hold out_ready low for 5 cycles
        apply_stimulus(3'b010, 1'b1, 32'hFFFFFFFD, 32'd7);
        check_output("mul_s.in_ready_busy", in_ready, 0);
        wait_result(60, lat);
        check_all("mul_s", lat, 33, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_output("stall.out_valid", out_valid, 1);
            check_output("stall.in_ready", in_ready, 0);
            check_output("stall.result", result, 32'hFFFFFFEB);
            check_output("stall.result_hi", result_hi, 32'hFFFFFFFF);
            check_output("stall.flags", {z, v, n}, 3'b001);
        end
        consume("mul_s");

        // Unsigned MUL with high half populated
        apply_stimulus(3'b010, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_result(60, lat);
        check_all("mul_u_big", lat, 33, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0);
        consume("mul_u_big");

        // Signed MUL overflowing into the high half, low half zero
        apply_stimulus(3'b010, 1'b1, 32'h00010000, 32'h00010000);
        wait_result(60, lat);
        check_all("mul_s_ovf", lat, 33, 32'h00000000, 32'h00000001, 1'b0, 1'b1, 1'b0);
        consume("mul_s_ovf");

        // Signed DIV -7 / 2 truncates toward zero, remainder follows a
        apply_stimulus(3'b011, 1'b1, 32'hFFFFFFF9, 32'd2);
        wait_result(60, lat);
        check_all("div_s", lat, 33, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
        consume("div_s");

        // Unsigned DIV 100 / 7
        apply_stimulus(3'b011, 1'b0, 32'd100, 32'd7);
        wait_result(60, lat);
        check_all("div_u", lat, 33, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
        consume("div_u");

        // DIV by zero completes immediately
        apply_stimulus(3'b011, 1'b0, 32'd5, 32'd0);
        wait_result(60, lat);
        check_all("div_by_zero", lat, 0, 32'hFFFFFFFF, 32'd5, 1'b0, 1'b1, 1'b0);
        consume("div_by_zero");

        // Signed most-negative / -1
        apply_stimulus(3'b011, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        wait_result(60, lat);
        check_all("div_s_ovf", lat, 33, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b1);
        consume("div_s_ovf");

        // Reserved op
        apply_stimulus(3'b101, 1'b1, 32'h11111111, 32'h22222222);
        wait_result(5, lat);
        check_all("reserved", lat, 0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        consume("reserved");

        // Reset pulsed at RUN cycle 10 of a MUL aborts it
        apply_stimulus(3'b010, 1'b0, 32'h12345678, 32'd9);
        repeat (10) @(posedge clk);
        #1;
        check_output("abort.busy_before", in_ready, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_output("abort.in_ready", in_ready, 1);
        check_output("abort.out_valid", out_valid, 0);
        check_output("abort.result", result, 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check_output("abort.no_pulse", seen, 0);
        check_output("abort.still_idle", in_ready, 1);

        // Recovery after the abort
        apply_stimulus(3'b000, 1'b1, 32'd2, 32'd3);
        wait_result(5, lat);
        check_all("add_recover", lat, 0, 32'd5, 32'h0, 1'b0, 1'b0, 1'b0);
        consume("add_recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
